qpd_request_gen: RTL and testbench

//  Initiator side of the quarter-period-delay trigger interface. Measures the period of the

---
 rtl/qpd_request_gen_if.sv | 12 +
 rtl/qpd_request_gen.sv | 193 +++++++++++++++++++
 tb/tb_qpd_request_gen.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpd_request_gen_if.sv
// Request/trigger link between the quarter-period request generator (master)
// and the delay/trigger block (slave).
interface qpd_request_gen_if #(
    parameter int COUNT_W = 8
);
    logic               rt;
    logic [COUNT_W-1:0] count_quater_period;
    logic               trigger;

    modport master (output rt, output count_quater_period, input trigger);
    modport slave  (input rt, input count_quater_period, output trigger);
endinterface

// File: rtl/qpd_request_gen.sv
// Measures the ref_in period, publishes the quarter period with an rt strobe and
// waits for the delay block's trigger (or a timeout) before measuring again.
module qpd_request_gen #(
    parameter int COUNT_W      = 8,
    parameter int PERIOD_W     = 32,
    parameter int MIN_PERIOD   = 8,
    parameter int RT_CYCLES    = 2,
    parameter int TRIG_TIMEOUT = 1000000
) (
    input  logic                sclock,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                ref_in,
    qpd_request_gen_if.master   req_if,
    output logic [PERIOD_W-1:0] last_period,
    output logic                busy,
    output logic                period_err,
    output logic                timeout_err
);

    localparam int TO_W = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;
    localparam int RC_W = (RT_CYCLES > 1) ? $clog2(RT_CYCLES) : 1;
    localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TRIG_TIMEOUT - 1);
    localparam logic [RC_W-1:0]     RC_LAST = RC_W'(RT_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] Q_MAX   = {{(PERIOD_W-COUNT_W){1'b0}}, {COUNT_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE_S      = 3'd0,
        ARM_S       = 3'd1,
        MEASURE_S   = 3'd2,
        REQUEST_S   = 3'd3,
        WAIT_TRIG_S = 3'd4
    } state_t;

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + PERIOD_W'(1);
        end
    endfunction

    function automatic logic [COUNT_W-1:0] quarter_sat(input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W-1:0] q;
        q = p >> 2'd2;
        if (q > Q_MAX) begin
            quarter_sat = {COUNT_W{1'b1}};
        end else begin
            quarter_sat = q[COUNT_W-1:0];
        end
    endfunction

    logic                ref_s1_r, ref_s2_r, ref_s3_r;
    logic                rise_s;
    state_t              state_r, state_n_s;
    logic [PERIOD_W-1:0] period_cnt_r, period_cnt_n_s;
    logic [RC_W-1:0]     req_cnt_r, req_cnt_n_s;
    logic [TO_W-1:0]     to_cnt_r, to_cnt_n_s;
    logic [COUNT_W-1:0]  count_r, count_n_s;
    logic [PERIOD_W-1:0] last_r, last_n_s;
    logic                rt_r, rt_n_s;
    logic                busy_r, busy_n_s;
    logic                perr_r, perr_n_s;
    logic                terr_r, terr_n_s;
    logic [PERIOD_W-1:0] period_s;
    logic [COUNT_W-1:0]  quarter_s;

    assign rise_s    = ref_s2_r & ~ref_s3_r;
    assign period_s  = sat_inc(period_cnt_r);
    assign quarter_s = quarter_sat(period_s);

    // Two-flop synchroniser plus edge-detect history for ref_in.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            ref_s1_r <= 1'b0;
            ref_s2_r <= 1'b0;
            ref_s3_r <= 1'b0;
        end else begin
            ref_s1_r <= ref_in;
            ref_s2_r <= ref_s1_r;
            ref_s3_r <= ref_s2_r;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n_s      = state_r;
        period_cnt_n_s = period_cnt_r;
        req_cnt_n_s    = req_cnt_r;
        to_cnt_n_s     = to_cnt_r;
        count_n_s      = count_r;
        last_n_s       = last_r;
        perr_n_s       = 1'b0;
        terr_n_s       = 1'b0;
        if (!enable) begin
            state_n_s      = IDLE_S;
            period_cnt_n_s = '0;
            req_cnt_n_s    = '0;
            to_cnt_n_s     = '0;
        end else begin
            case (state_r)
                IDLE_S: state_n_s = ARM_S;
                ARM_S: begin
                    if (rise_s) begin
                        period_cnt_n_s = '0;
                        state_n_s      = MEASURE_S;
                    end else begin
                        state_n_s = ARM_S;
                    end
                end
                MEASURE_S: begin
                    if (rise_s) begin
                        // The closing edge always opens the next measurement.
                        period_cnt_n_s = '0;
                        if (period_s < MIN_P) begin
                            perr_n_s = 1'b1;
                        end else begin
                            last_n_s = period_s;
                            // The delay block only fires on a changed count, so skip repeats.
                            if (quarter_s == count_r) begin
                                state_n_s = MEASURE_S;
                            end else begin
                                count_n_s   = quarter_s;
                                req_cnt_n_s = '0;
                                state_n_s   = REQUEST_S;
                            end
                        end
                    end else begin
                        period_cnt_n_s = sat_inc(period_cnt_r);
                    end
                end
                REQUEST_S: begin
                    if (req_cnt_r == RC_LAST) begin
                        to_cnt_n_s = '0;
                        state_n_s  = WAIT_TRIG_S;
                    end else begin
                        req_cnt_n_s = req_cnt_r + RC_W'(1);
                    end
                end
                WAIT_TRIG_S: begin
                    if (req_if.trigger) begin
                        state_n_s = ARM_S;
                    end else if (to_cnt_r == TO_LAST) begin
                        terr_n_s  = 1'b1;
                        state_n_s = ARM_S;
                    end else begin
                        to_cnt_n_s = to_cnt_r + TO_W'(1);
                    end
                end
                default: state_n_s = IDLE_S;
            endcase
        end
        // rt trails the count update by one cycle, so the count is settled when rt rises.
        rt_n_s   = (state_r == REQUEST_S) && enable;
        busy_n_s = (state_n_s != IDLE_S);
    end

    // State, counters and registered outputs.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE_S;
            period_cnt_r <= '0;
            req_cnt_r    <= '0;
            to_cnt_r     <= '0;
            count_r      <= '0;
            last_r       <= '0;
            rt_r         <= 1'b0;
            busy_r       <= 1'b0;
            perr_r       <= 1'b0;
            terr_r       <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            period_cnt_r <= period_cnt_n_s;
            req_cnt_r    <= req_cnt_n_s;
            to_cnt_r     <= to_cnt_n_s;
            count_r      <= count_n_s;
            last_r       <= last_n_s;
            rt_r         <= rt_n_s;
            busy_r       <= busy_n_s;
            perr_r       <= perr_n_s;
            terr_r       <= terr_n_s;
        end
    end

    assign req_if.rt                  = rt_r;
    assign req_if.count_quater_period = count_r;
    assign last_period                = last_r;
    assign busy                       = busy_r;
    assign period_err                 = perr_r;
    assign timeout_err                = terr_r;

endmodule

// File: tb/tb_qpd_request_gen.sv
// Randomised bench for qpd_request_gen: a timestamp-based reference model is
// compared against the outputs every cycle, plus literal checks on key scenarios.
module tb_qpd_request_gen;

    localparam int COUNT_W      = 8;
    localparam int PERIOD_W     = 32;
    localparam int MIN_PERIOD   = 8;
    localparam int RT_CYCLES    = 2;
    localparam int TRIG_TIMEOUT = 50;

    localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_REQ = 3, M_WAIT = 4;

    logic                sclock = 1'b0;
    logic                rst_n  = 1'b0;
    logic                enable = 1'b0;
    logic                ref_in = 1'b0;
    logic [PERIOD_W-1:0] last_period;
    logic                busy, period_err, timeout_err;

    qpd_request_gen_if #(.COUNT_W(COUNT_W)) qif ();

    qpd_request_gen #(
        .COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W), .MIN_PERIOD(MIN_PERIOD),
        .RT_CYCLES(RT_CYCLES), .TRIG_TIMEOUT(TRIG_TIMEOUT)
    ) dut (
        .sclock(sclock), .rst_n(rst_n), .enable(enable), .ref_in(ref_in),
        .req_if(qif), .last_period(last_period), .busy(busy),
        .period_err(period_err), .timeout_err(timeout_err)
    );

    always #5 sclock = ~sclock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps, not counters) ----------------
    int n_edge = 0;
    int m_phase = M_IDLE;
    int m_start = 0, m_req_edge = 0, m_wait_edge = 0;
    bit r1 = 0, r2 = 0, r3 = 0;
    int exp_cnt = 0, exp_last = 0;
    bit exp_rt = 0, exp_busy = 0, exp_perr = 0, exp_terr = 0;
    int coinc = 0;

    task automatic model_reset();
        m_phase = M_IDLE;
        r1 = 0; r2 = 0; r3 = 0;
        exp_cnt = 0; exp_last = 0;
        exp_rt = 0; exp_busy = 0; exp_perr = 0; exp_terr = 0;
    endtask

    task automatic model_step();
        bit rise;
        int ph, p, q;
        rise = r2 & ~r3;
        ph   = m_phase;
        r3 = r2; r2 = r1; r1 = ref_in;
        n_edge++;
        exp_rt = 0; exp_perr = 0; exp_terr = 0;
        if (!enable) begin
            m_phase = M_IDLE;
        end else begin
            case (ph)
                M_IDLE: m_phase = M_ARM;
                M_ARM: if (rise) begin m_start = n_edge; m_phase = M_MEAS; end
                M_MEAS: if (rise) begin
                    p = n_edge - m_start;
                    m_start = n_edge;
                    if (p < MIN_PERIOD) exp_perr = 1;
                    else begin
                        exp_last = p;
                        q = (p / 4 > 255) ? 255 : p / 4;
                        if (q != exp_cnt) begin
                            exp_cnt = q; m_req_edge = n_edge; m_phase = M_REQ;
                        end
                    end
                end
                M_REQ: begin
                    exp_rt = 1;
                    if (n_edge == m_req_edge + RT_CYCLES) begin
                        m_phase = M_WAIT; m_wait_edge = n_edge;
                    end
                end
                M_WAIT: begin
                    if (qif.trigger) begin
                        if (n_edge - m_wait_edge == TRIG_TIMEOUT) coinc++;
                        m_phase = M_ARM;
                    end else if (n_edge - m_wait_edge == TRIG_TIMEOUT) begin
                        exp_terr = 1; m_phase = M_ARM;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
        exp_busy = (m_phase != M_IDLE);
    endtask

    initial forever begin
        @(posedge sclock or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare and event monitors ----------------
    int  rt_rises = 0, rt_run = 0, rt_len = 0, perr_cnt = 0, terr_cnt = 0;
    bit  rt_q = 0;

    initial forever begin
        @(negedge sclock);
        check("rt", qif.rt, exp_rt);
        check("count", qif.count_quater_period, exp_cnt);
        check("last_period", last_period, exp_last);
        check("busy", busy, exp_busy);
        check("period_err", period_err, exp_perr);
        check("timeout_err", timeout_err, exp_terr);
        if (qif.rt) begin
            if (!rt_q) rt_rises++;
            rt_run++;
        end else begin
            if (rt_q) rt_len = rt_run;
            rt_run = 0;
        end
        rt_q = qif.rt;
        if (period_err)  perr_cnt++;
        if (timeout_err) terr_cnt++;
    end

    // ---------------- reference waveform generator ----------------
    int ref_per = 0, ref_hi = 0, ref_lo = 0;
    initial forever begin
        if (ref_per < 2) begin
            @(negedge sclock); #1 ref_in = 1'b0;
        end else begin
            ref_hi = ref_per / 2;
            ref_lo = ref_per - ref_hi;
            @(negedge sclock); #1 ref_in = 1'b1;
            repeat (ref_hi - 1) @(negedge sclock);
            @(negedge sclock); #1 ref_in = 1'b0;
            repeat (ref_lo - 1) @(negedge sclock);
        end
    end

    // ---------------- delay-block responder ----------------
    // mode 0: random delay before timeout, 1: never, 2: exactly at timeout expiry
    int trig_mode = 0;
    bit rt_prev = 0;
    initial begin
        qif.trigger = 1'b0;
        forever begin
            int d;
            @(negedge sclock); #1;
            if (qif.rt && !rt_prev) begin
                case (trig_mode)
                    0:       d = $urandom_range(0, 45);
                    2:       d = RT_CYCLES + TRIG_TIMEOUT - 2;
                    default: d = -1;
                endcase
                if (d >= 0) begin
                    if (d > 0) begin
                        repeat (d) @(negedge sclock);
                        #1;
                    end
                    qif.trigger = 1'b1;
                    @(negedge sclock); #1 qif.trigger = 1'b0;
                end
            end
            rt_prev = qif.rt;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge sclock); #2;
    endtask

    task automatic bounded(input string name, input bit seen, input int waited, input int bound);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: event not seen after %0d cycles, required within %0d", name, waited, bound);
        end
    endtask

    task automatic wait_rt_rise(input string name, input int bound);
        int r0, i;
        bit seen;
        r0 = rt_rises; seen = 0; i = 0;
        while (i < bound && !seen) begin
            tick(); i++;
            if (rt_rises != r0) seen = 1;
        end
        bounded(name, seen, i, bound);
    endtask

    task automatic wait_count(input string name, input int val, input int bound);
        int i;
        bit seen;
        seen = 0; i = 0;
        while (i < bound && !seen) begin
            tick(); i++;
            if (qif.count_quater_period == val) seen = 1;
        end
        bounded(name, seen, i, bound);
    endtask

    task automatic wait_terr(input string name, input int bound);
        int t0, i;
        bit seen;
        t0 = terr_cnt; seen = 0; i = 0;
        while (i < bound && !seen) begin
            tick(); i++;
            if (terr_cnt != t0) seen = 1;
        end
        bounded(name, seen, i, bound);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // ---------------- scenario sequence ----------------
    initial begin
        int r0, p0, t0, cyc;
        repeat (3) tick();
        check("reset_rt", qif.rt, 0);
        check("reset_count", qif.count_quater_period, 0);
        check("reset_last", last_period, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // 400-cycle reference: quarter 100, rt two cycles
        ref_per = 400; trig_mode = 0; enable = 1'b1;
        wait_rt_rise("wait_first_rt", 1500);
        check("t1_count", qif.count_quater_period, 100);
        check("t1_last", last_period, 400);
        check("t1_model_count", exp_cnt, 100);
        repeat (4) tick();
        check("t1_rt_len", rt_len, 2);

        // same period again: no request; then 480 gives 120
        r0 = rt_rises;
        repeat (1300) tick();
        check("t2_no_rt_same_q", rt_rises, r0);
        ref_per = 480;
        wait_count("wait_count_120", 120, 2500);
        check("t2_last", last_period, 480);
        check("t2_busy", busy, 1);
        repeat (5) tick();

        // short periods: period_err pulses, no requests
        ref_per = 5;
        r0 = rt_rises; p0 = perr_cnt;
        repeat (1000) tick();
        check("t3_perr_many", (perr_cnt - p0) >= 80, 1);
        check("t3_no_rt", rt_rises, r0);

        // long period saturates to 255; no trigger so timeout
        ref_per = 2000; trig_mode = 1;
        wait_count("wait_count_255", 255, 4500);
        check("t4_last", last_period, 2000);
        t0 = terr_cnt;
        wait_terr("wait_timeout", 200);
        repeat (100) tick();
        check("t4_one_timeout", terr_cnt - t0, 1);
        check("t4_busy_arm", busy, 1);

        // trigger on the timeout-expiry cycle: trigger wins
        ref_per = 600; trig_mode = 2;
        wait_count("wait_count_150", 150, 5000);
        t0 = terr_cnt;
        repeat (100) tick();
        check("t6_no_timeout", terr_cnt, t0);
        check("t6_coincident_seen", coinc > 0, 1);
        check("t6_busy", busy, 1);

        // disable during the first rt cycle, then async reset mid-measure
        ref_per = 800; trig_mode = 0;
        wait_rt_rise("wait_rt_800", 3000);
        enable = 1'b0;
        tick();
        check("t5_rt_dropped", qif.rt, 0);
        check("t5_busy_low", busy, 0);
        check("t5_count_held", qif.count_quater_period, 200);
        enable = 1'b1;
        repeat (1000) tick();
        check("t5_last_800", last_period, 800);
        rst_n = 1'b0;
        #1;
        check("t5_arst_rt", qif.rt, 0);
        check("t5_arst_count", qif.count_quater_period, 0);
        check("t5_arst_last", last_period, 0);
        check("t5_arst_busy", busy, 0);
        check("t5_arst_errs", {period_err, timeout_err}, 0);
        tick(); tick();
        rst_n = 1'b1;

        // randomised periods, responder modes and enable drops
        for (int it = 0; it < 8; it++) begin
            ref_per   = $urandom_range(4, 700);
            trig_mode = $urandom_range(0, 2);
            cyc       = $urandom_range(600, 2000);
            for (int c = 0; c < cyc; c++) begin
                tick();
                if ($urandom_range(0, 399) == 0) enable = ~enable;
            end
            enable = 1'b1;
        end

        ref_per = 0;
        repeat (20) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
